apple_icon_overlay: RTL
=======================

APPLE_ICON_OVERLAY -- requirements
Module: apple_icon_overlay

Interface
REQ-001 Parameter ICON_W, 64, icon width in pixels; power of two.
REQ-002 Parameter ICON_H, 64, icon height in pixels; power of two.
REQ-003 Parameter ADDR_W, 12, ROM address width; equals log2(ICON_W)+log2(ICON_H).
REQ-004 Parameter ROM_LAT, 1, cycles from rom_addr to valid rom_data (1 or 2).
REQ-005 Parameter KEY_COLOR, 16'hF81F, RGB565 transparent key.
REQ-006 clk  in  1  single pixel clock; all logic on rising edge.
REQ-007 rst_n  in  1  reset, synchronous, active-low.
REQ-008 vs_in / hs_in / de_in  in  1 each  input video timing; vs_in active-high.
REQ-009 rgb_in  in  16  input RGB565 pixel, qualified by de_in.
REQ-010 show_en  in  1  request to draw icon (fruit = apple).
REQ-011 icon_x / icon_y  in  11 each  icon top-left position in active pixels.
REQ-012 rom_addr  out  ADDR_W  address to apple image ROM.
REQ-013 rom_data  in  16  ROM read data, RGB565.
REQ-014 vs_out / hs_out / de_out  out  1 each  delayed timing.
REQ-015 rgb_out  out  16  overlaid pixel.

Function
REQ-016 Column counter col (11 b) SHALL increment each de_in=1 cycle and clear on the cycle after de_in falls.
REQ-017 Row counter row (11 b) SHALL increment on each de_in falling edge and clear on vs_in rising edge.
REQ-018 On vs_in rising edge, show_en, icon_x, icon_y SHALL be captured into shadow registers; mid-frame changes SHALL NOT affect the current frame.
REQ-019 in_win SHALL be de_in & shadow_en & col in [x, x+ICON_W-1] & row in [y, y+ICON_H-1], compared at 12 b to avoid overflow.
REQ-020 rom_addr SHALL equal {row-y, col-x} (low log2 bits) when in_win, else 0; driven combinationally from registered counters.
REQ-021 vs/hs/de/rgb and in_win SHALL be delayed ROM_LAT cycles to align with rom_data.
REQ-022 rgb_out SHALL be rom_data when delayed in_win=1 and rom_data!=KEY_COLOR, else delayed rgb_in; registered.
REQ-023 Total input-to-output latency SHALL be ROM_LAT+1 cycles for all outputs.
REQ-024 Icon extending past right/bottom active edge SHALL be clipped; visible pixels keep correct addresses.
REQ-025 rgb_out SHALL be 0 when de_out=0.
REQ-026 Simultaneous vs_in rise and de_in: vs handling (row clear, shadow capture) takes effect first.

Reset
REQ-027 While rst_n=0 at a clock edge: counters, shadow regs, delay pipeline, all outputs SHALL clear to 0.
REQ-028 After reset release, overlay SHALL remain off (pass-through) until the next vs_in rising edge.
REQ-029 Reset mid-frame SHALL NOT produce partial icon pixels in the remainder of that frame.

Structure
REQ-030 Package apple_overlay_pkg SHALL hold RGB565 width, KEY_COLOR default, coordinate width (11).
REQ-031 Sub-module video_delay_line (parameter depth, width) SHALL implement the ROM_LAT alignment pipe.
REQ-032 The ROM SHALL be instantiated outside this block, at the display top level.

Verification
REQ-033 show_en=0, 1920x1080 ramp input -> rgb_out equals rgb_in delayed 2 cycles (ROM_LAT=1), rom_addr stays 0.
REQ-034 show_en=1, icon (0,0), ROM model data=addr -> line 0 pixels 0..63 out 0x0000..0x003F, pixel 64 pass-through; line 1 starts 0x0040.
REQ-035 ROM model returns 16'hF81F at addr 5 -> pixel (5,0) shows rgb_in, neighbours show ROM.
REQ-036 icon_x=1890, icon_y=1050 -> 30 columns, 30 rows drawn; row 1 first address 0x040; nothing wraps to column 0.
REQ-037 show_en toggled 1->0 mid-frame -> icon completes this frame, absent next frame.
REQ-038 rst_n low 1 cycle mid-icon-line -> all outputs 0 next cycle, pass-through until next vs_in rise, icon on following frame.

Source files
------------

// File: rtl/apple_icon_overlay_pkg.sv
// Shared types and constants for the apple icon overlay.
// Holds RGB565 width, transparent key default and coordinate width.
package apple_overlay_pkg;

  localparam int RGB_W = 16;
  localparam int COORD_W = 11;
  localparam logic [RGB_W-1:0] KEY_COLOR_DEF = 16'hF81F;

  typedef logic [RGB_W-1:0] rgb565_t;
  typedef logic [COORD_W-1:0] coord_t;

  // Timing + pixel bundle carried through the ROM alignment pipe
  typedef struct packed {
    logic    vs;
    logic    hs;
    logic    de;
    rgb565_t rgb;
    logic    win;
  } vid_t;

  // Blanking forces black; key-coloured ROM pixels let video through
  function automatic rgb565_t overlay_px(
    input logic    de,
    input logic    win,
    input rgb565_t rom,
    input rgb565_t vid,
    input rgb565_t key
  );
    if (!de)
      return '0;
    if (win && rom != key)
      return rom;
    return vid;
  endfunction

endpackage

// File: rtl/apple_icon_overlay_if.sv
// Video stream bundle: timing/pixel into the overlay and back out.
// master = video source/sink side, slave = overlay side.
interface apple_icon_overlay_if;
  import apple_overlay_pkg::*;

  logic    vs_in;
  logic    hs_in;
  logic    de_in;
  rgb565_t rgb_in;
  logic    vs_out;
  logic    hs_out;
  logic    de_out;
  rgb565_t rgb_out;

  modport master (
    output vs_in,
    output hs_in,
    output de_in,
    output rgb_in,
    input  vs_out,
    input  hs_out,
    input  de_out,
    input  rgb_out
  );

  modport slave (
    input  vs_in,
    input  hs_in,
    input  de_in,
    input  rgb_in,
    output vs_out,
    output hs_out,
    output de_out,
    output rgb_out
  );

endinterface

// File: rtl/apple_icon_overlay_delay.sv
// video_delay_line: DEPTH-stage register pipe, WIDTH bits wide.
// Ports: clk, rst_n (sync, active-low), din, dout.
module video_delay_line #(
  parameter int DEPTH = 1,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/apple_icon_overlay.sv
// Overlays an apple icon from external ROM onto RGB565 video.
// Ports: clk, rst_n, vid (video in/out), show_en, icon_x/y, rom_addr/data.
module apple_icon_overlay
  import apple_overlay_pkg::*;
#(
  parameter int      ICON_W    = 64,
  parameter int      ICON_H    = 64,
  parameter int      ADDR_W    = 12,
  parameter int      ROM_LAT   = 1,
  parameter rgb565_t KEY_COLOR = KEY_COLOR_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  apple_icon_overlay_if.slave vid,
  input  logic                show_en,
  input  coord_t              icon_x,
  input  coord_t              icon_y,
  output logic [ADDR_W-1:0]   rom_addr,
  input  rgb565_t             rom_data
);

  localparam int XW = $clog2(ICON_W);
  localparam int YW = $clog2(ICON_H);

  coord_t col;
  coord_t row;
  logic   vs_q;
  logic   de_q;
  logic   sh_en;
  coord_t sh_x;
  coord_t sh_y;

  logic   vs_rise;
  logic   de_fall;

  assign vs_rise = vid.vs_in & ~vs_q;
  assign de_fall = de_q & ~vid.de_in;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col   <= '0;
      row   <= '0;
      vs_q  <= 1'b0;
      de_q  <= 1'b0;
      sh_en <= 1'b0;
      sh_x  <= '0;
      sh_y  <= '0;
    end else begin
      vs_q <= vid.vs_in;
      de_q <= vid.de_in;
      col  <= vid.de_in ? col + coord_t'(1) : '0;
      if (vs_rise)
        row <= '0;
      else if (de_fall)
        row <= row + coord_t'(1);
      if (vs_rise) begin
        sh_en <= show_en;
        sh_x  <= icon_x;
        sh_y  <= icon_y;
      end
    end
  end

  // A vs rise lands on this pixel already: bypass the
  // shadow regs and the row counter for that one cycle.
  logic   act_en;
  coord_t act_x;
  coord_t act_y;
  coord_t act_row;

  always_comb begin
    act_en  = sh_en;
    act_x   = sh_x;
    act_y   = sh_y;
    act_row = row;
    if (vs_rise) begin
      act_en  = show_en;
      act_x   = icon_x;
      act_y   = icon_y;
      act_row = '0;
    end
  end

  // One extra bit so x+ICON_W-1 cannot wrap
  logic [11:0] c12;
  logic [11:0] r12;
  logic [11:0] x12;
  logic [11:0] y12;
  logic [11:0] xe12;
  logic [11:0] ye12;
  logic        in_x;
  logic        in_y;
  logic        in_win;

  assign c12  = {1'b0, col};
  assign r12  = {1'b0, act_row};
  assign x12  = {1'b0, act_x};
  assign y12  = {1'b0, act_y};
  assign xe12 = x12 + 12'(ICON_W - 1);
  assign ye12 = y12 + 12'(ICON_H - 1);
  assign in_x = (c12 >= x12) && (c12 <= xe12);
  assign in_y = (r12 >= y12) && (r12 <= ye12);

  assign in_win = vid.de_in & act_en & in_x & in_y;

  logic [XW-1:0] dx;
  logic [YW-1:0] dy;

  assign dx = col[XW-1:0] - act_x[XW-1:0];
  assign dy = act_row[YW-1:0] - act_y[YW-1:0];

  assign rom_addr = in_win ? {dy, dx} : '0;

  vid_t dly_in;
  vid_t dly_out;

  always_comb begin
    dly_in     = '0;
    dly_in.vs  = vid.vs_in;
    dly_in.hs  = vid.hs_in;
    dly_in.de  = vid.de_in;
    dly_in.rgb = vid.rgb_in;
    dly_in.win = in_win;
  end

  video_delay_line #(
    .DEPTH (ROM_LAT),
    .WIDTH ($bits(vid_t))
  ) u_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (dly_in),
    .dout  (dly_out)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vid.vs_out  <= 1'b0;
      vid.hs_out  <= 1'b0;
      vid.de_out  <= 1'b0;
      vid.rgb_out <= '0;
    end else begin
      vid.vs_out  <= dly_out.vs;
      vid.hs_out  <= dly_out.hs;
      vid.de_out  <= dly_out.de;
      vid.rgb_out <= overlay_px(dly_out.de,
                                dly_out.win,
                                rom_data,
                                dly_out.rgb,
                                KEY_COLOR);
    end
  end

endmodule
